// File: rtl/vga_pkg.sv
// Shared VGA definitions: default coordinate/colour widths, the rectangle
// configuration record and a small span-compare helper reused by overlay blocks.
package vga_pkg;

    localparam int VGA_COORD_W = 10;
    localparam int VGA_COLOR_W = 8;

    // One rectangle's programmable state; bounds are inclusive.
    typedef struct packed {
        logic [VGA_COORD_W-1:0] x0;
        logic [VGA_COORD_W-1:0] x1;
        logic [VGA_COORD_W-1:0] y0;
        logic [VGA_COORD_W-1:0] y1;
        logic [VGA_COLOR_W-1:0] color;
        logic                   en;
        logic                   blink;
    } rect_cfg_t;

    localparam rect_cfg_t RECT_CFG_RESET = '0;

    // Unsigned inclusive span test; an inverted span (lo > hi) never matches.
    function automatic logic in_span(input logic [VGA_COORD_W-1:0] lo,
                                     input logic [VGA_COORD_W-1:0] hi,
                                     input logic [VGA_COORD_W-1:0] pos);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/rect_draw_if.sv
// Pixel stream, configuration write bus and overlay result of rect_draw.
// master = the controller side driving pixels/config, slave = rect_draw.
interface rect_draw_if #(
    parameter int NUM_RECTS = 4,
    parameter int COORD_W   = vga_pkg::VGA_COORD_W,
    parameter int COLOR_W   = vga_pkg::VGA_COLOR_W
);
    localparam int IDX_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;

    // pixel stream
    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               pix_valid;
    logic               frame_start;

    // configuration write bus
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [COORD_W-1:0] cfg_x0;
    logic [COORD_W-1:0] cfg_x1;
    logic [COORD_W-1:0] cfg_y0;
    logic [COORD_W-1:0] cfg_y1;
    logic [COLOR_W-1:0] cfg_color;
    logic               cfg_en;
    logic               cfg_blink;

    // overlay result
    logic               draw;
    logic [COLOR_W-1:0] color;
    logic [IDX_W-1:0]   hit_idx;
    logic               draw_valid;

    modport master (
        output hcount, vcount, pix_valid, frame_start,
        output cfg_we, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1,
        output cfg_color, cfg_en, cfg_blink,
        input  draw, color, hit_idx, draw_valid
    );

    modport slave (
        input  hcount, vcount, pix_valid, frame_start,
        input  cfg_we, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1,
        input  cfg_color, cfg_en, cfg_blink,
        output draw, color, hit_idx, draw_valid
    );

endinterface

// File: rtl/rect_hit.sv
// Combinational coverage test of one pixel against one rectangle:
// enabled, inside both inclusive spans, and not hidden by the blink phase.
module rect_hit
    import vga_pkg::*;
(
    input  rect_cfg_t              cfg,
    input  logic [VGA_COORD_W-1:0] hcount,
    input  logic [VGA_COORD_W-1:0] vcount,
    input  logic                   phase,
    output logic                   hit
);

    // Blink hides the rectangle while the frame-derived phase is high.
    always_comb begin
        hit = cfg.en
            & in_span(cfg.x0, cfg.x1, hcount)
            & in_span(cfg.y0, cfg.y1, vcount)
            & ~(cfg.blink & phase);
    end

endmodule

// File: rtl/rect_draw.sv
// Rectangle overlay: double-buffered rectangle bank committed at frame start,
// blink frame counter, and a two-stage pipeline (hit vector, then priority
// encode) producing draw/color/hit_idx aligned with draw_valid.
module rect_draw
    import vga_pkg::*;
#(
    parameter int NUM_RECTS = 4,
    parameter int COORD_W   = VGA_COORD_W,
    parameter int COLOR_W   = VGA_COLOR_W,
    parameter int BLINK_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    rect_draw_if.slave  bus
);

    localparam int IDX_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;

    // configuration banks and frame counter
    rect_cfg_t          shadow_q [NUM_RECTS];
    rect_cfg_t          shadow_d [NUM_RECTS];
    rect_cfg_t          active_q [NUM_RECTS];
    rect_cfg_t          active_d [NUM_RECTS];
    logic [BLINK_W-1:0] frame_cnt_q;
    logic [BLINK_W-1:0] frame_cnt_d;

    rect_cfg_t          wr_cfg;
    logic               wr_ok;
    logic               phase;
    logic [NUM_RECTS-1:0] hit_vec;

    // stage 1
    logic [NUM_RECTS-1:0] hit_vec_p1_q;
    logic [NUM_RECTS-1:0] hit_vec_p1_d;
    logic [COLOR_W-1:0]   color_vec_p1_q [NUM_RECTS];
    logic [COLOR_W-1:0]   color_vec_p1_d [NUM_RECTS];
    logic                 vld_p1_q;
    logic                 vld_p1_d;

    // stage 2
    logic                 draw_p2_q;
    logic                 draw_p2_d;
    logic [COLOR_W-1:0]   color_p2_q;
    logic [COLOR_W-1:0]   color_p2_d;
    logic [IDX_W-1:0]     hit_idx_p2_q;
    logic [IDX_W-1:0]     hit_idx_p2_d;
    logic                 vld_p2_q;
    logic                 vld_p2_d;

    assign wr_cfg = '{x0:    bus.cfg_x0,
                      x1:    bus.cfg_x1,
                      y0:    bus.cfg_y0,
                      y1:    bus.cfg_y1,
                      color: bus.cfg_color,
                      en:    bus.cfg_en,
                      blink: bus.cfg_blink};

    // Writes to non-existent rectangles are dropped.
    assign wr_ok = bus.cfg_we && (int'(bus.cfg_idx) < NUM_RECTS);

    assign phase = frame_cnt_q[BLINK_W-1];

    // Next bank state: the write lands in the shadow first so a same-cycle
    // frame_start commits the freshly written value.
    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        frame_cnt_d = frame_cnt_q;
        if (wr_ok) begin
            shadow_d[bus.cfg_idx] = wr_cfg;
        end
        if (bus.frame_start) begin
            active_d    = shadow_d;
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // Bank and frame counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                shadow_q[i] <= RECT_CFG_RESET;
                active_q[i] <= RECT_CFG_RESET;
            end
            frame_cnt_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // One coverage checker per active rectangle.
    for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
        rect_hit u_hit (
            .cfg    (active_q[g]),
            .hcount (bus.hcount),
            .vcount (bus.vcount),
            .phase  (phase),
            .hit    (hit_vec[g])
        );
    end

    // ---- stage 0 -> 1: hit vector, pixel-valid and the colours that go with it.
    // Colours are captured with the hits so a commit between stages cannot
    // pair a hit with a colour from the next frame's bank.
    always_comb begin
        hit_vec_p1_d = bus.pix_valid ? hit_vec : '0;
        vld_p1_d     = bus.pix_valid;
        for (int i = 0; i < NUM_RECTS; i++) begin
            color_vec_p1_d[i] = active_q[i].color;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_vec_p1_q <= '0;
            vld_p1_q     <= 1'b0;
            for (int i = 0; i < NUM_RECTS; i++) begin
                color_vec_p1_q[i] <= '0;
            end
        end else begin
            hit_vec_p1_q   <= hit_vec_p1_d;
            vld_p1_q       <= vld_p1_d;
            color_vec_p1_q <= color_vec_p1_d;
        end
    end

    // ---- stage 1 -> 2: priority encode, lowest index wins. Invalid pixels
    // carry an all-zero hit vector, so their outputs fall out as zero.
    always_comb begin
        draw_p2_d    = |hit_vec_p1_q;
        color_p2_d   = '0;
        hit_idx_p2_d = '0;
        vld_p2_d     = vld_p1_q;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (hit_vec_p1_q[i]) begin
                color_p2_d   = color_vec_p1_q[i];
                hit_idx_p2_d = IDX_W'(i);
            end
        end
    end

    // Stage 2 (output) registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            draw_p2_q    <= 1'b0;
            color_p2_q   <= '0;
            hit_idx_p2_q <= '0;
            vld_p2_q     <= 1'b0;
        end else begin
            draw_p2_q    <= draw_p2_d;
            color_p2_q   <= color_p2_d;
            hit_idx_p2_q <= hit_idx_p2_d;
            vld_p2_q     <= vld_p2_d;
        end
    end

    assign bus.draw       = draw_p2_q;
    assign bus.color      = color_p2_q;
    assign bus.hit_idx    = hit_idx_p2_q;
    assign bus.draw_valid = vld_p2_q;

endmodule
